// File: rtl/slc3_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | slc3_pkg: shared types, opcodes, FSM states and helpers for SLC-3 |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package slc3_pkg;

    localparam int MEM_DEPTH = 256;

    typedef logic [15:0] word_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    typedef enum logic [4:0] {
        S_HALTED, S_18, S_33, S_35, S_32,
        S_ADD, S_AND, S_NOT, S_BR,
        S_LDR1, S_LDR2, S_LDR3,
        S_STR1, S_STR2, S_STR3,
        S_PAUSE1, S_PAUSE2
    } state_t;

    function automatic word_t sext5(input logic [4:0] v);
        return {{11{v[4]}}, v};
    endfunction

    function automatic word_t sext6(input logic [5:0] v);
        return {{10{v[5]}}, v};
    endfunction

    function automatic word_t sext9(input logic [8:0] v);
        return {{7{v[8]}}, v};
    endfunction

    // nzp condition code for a value written to a register
    function automatic logic [2:0] cc_of(input word_t v);
        if (v[15])
            return 3'b100;
        else if (v == 16'h0000)
            return 3'b010;
        else
            return 3'b001;
    endfunction

endpackage
`default_nettype wire

// File: rtl/slc3_hexdriver.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hexdriver: 4-bit nibble to active-low seven-segment glyph {g..a}  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module hexdriver (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'h7F;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/slc3_testtop.sv
`default_nettype none
// +------------------------------------------------------------------+
// | slc3_testtop: multi-cycle SLC-3 core with 256x16 internal memory  |
// | Optional macro SLC3_HEX_DISPLAY_EN shows IR/PC on HEX7..HEX0.     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module slc3_testtop
    import slc3_pkg::*;
(
    input  logic        Clk,
    input  logic        Run,
    input  logic        Continue,
    input  logic [9:0]  SW,
    output logic [9:0]  LED,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX6,
    output logic [6:0]  HEX7,
    output logic [19:0] ADDR,
    output logic [15:0] MARTESTOUT,
    output logic [15:0] PCTESTOUT,
    output logic [15:0] MDRTESTOUT
);

    logic   run_ah, continue_ah, reset_ah;
    state_t state, next_state;
    word_t  pc, mar, mdr, ir;
    word_t  regs [8];
    logic [2:0] cc;
    logic [9:0] led;

    word_t mem [MEM_DEPTH] = '{0: 16'h5020, 1: 16'h1023, 2: 16'hD0AA,
                               3: 16'h7050, 4: 16'h6450, 5: 16'h0FFC,
                               default: 16'h0000};

    word_t mem_rdata, op2, add_res, and_res, not_res, eff_addr;
    logic  br_taken;

    assign run_ah      = ~Run;
    assign continue_ah = ~Continue;
    assign reset_ah    = run_ah & continue_ah;

    // The switches are memory-mapped at the very top of the address space
    assign mem_rdata = (mar == 16'hFFFF) ? {6'b0, SW} : mem[mar[7:0]];
    assign op2       = ir[5] ? sext5(ir[4:0]) : regs[ir[2:0]];
    assign add_res   = regs[ir[8:6]] + op2;
    assign and_res   = regs[ir[8:6]] & op2;
    assign not_res   = ~regs[ir[8:6]];
    assign eff_addr  = regs[ir[8:6]] + sext6(ir[5:0]);
    assign br_taken  = |(ir[11:9] & cc);

    always_ff @(posedge Clk) begin
        if (reset_ah)
            state <= S_HALTED;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_HALTED: if (run_ah && !continue_ah) next_state = S_18;
            S_18:     next_state = S_33;
            S_33:     next_state = S_35;
            S_35:     next_state = S_32;
            S_32: begin
                case (ir[15:12])
                    OP_ADD:   next_state = S_ADD;
                    OP_AND:   next_state = S_AND;
                    OP_NOT:   next_state = S_NOT;
                    OP_BR:    next_state = S_BR;
                    OP_LDR:   next_state = S_LDR1;
                    OP_STR:   next_state = S_STR1;
                    OP_PAUSE: next_state = S_PAUSE1;
                    default:  next_state = S_18;
                endcase
            end
            S_LDR1:   next_state = S_LDR2;
            S_LDR2:   next_state = S_LDR3;
            S_STR1:   next_state = S_STR2;
            S_STR2:   next_state = S_STR3;
            S_PAUSE1: if (continue_ah)  next_state = S_PAUSE2;
            S_PAUSE2: if (!continue_ah) next_state = S_18;
            default:  next_state = S_18;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset_ah) begin
            pc  <= '0;
            mar <= '0;
            mdr <= '0;
            ir  <= '0;
            cc  <= 3'b010;
            led <= '0;
            for (int i = 0; i < 8; i++)
                regs[i] <= '0;
        end else begin
            case (state)
                S_18: begin
                    mar <= pc;
                    pc  <= pc + 16'd1;
                end
                S_33, S_LDR2: mdr <= mem_rdata;
                S_35:   ir <= mdr;
                S_ADD: begin
                    regs[ir[11:9]] <= add_res;
                    cc             <= cc_of(add_res);
                end
                S_AND: begin
                    regs[ir[11:9]] <= and_res;
                    cc             <= cc_of(and_res);
                end
                S_NOT: begin
                    regs[ir[11:9]] <= not_res;
                    cc             <= cc_of(not_res);
                end
                S_BR:   if (br_taken) pc <= pc + sext9(ir[8:0]);
                S_LDR1, S_STR1: mar <= eff_addr;
                S_LDR3: begin
                    regs[ir[11:9]] <= mdr;
                    cc             <= cc_of(mdr);
                end
                S_STR2:   mdr <= regs[ir[11:9]];
                S_PAUSE1: led <= ir[9:0];
                default: ;
            endcase
        end
    end

    // Memory is never cleared, so the program image survives a reset
    always_ff @(posedge Clk) begin
        if (!reset_ah && state == S_STR3)
            mem[mar[7:0]] <= mdr;
    end

    assign LED        = led;
    assign ADDR       = {4'h0, mar};
    assign MARTESTOUT = mar;
    assign PCTESTOUT  = pc;
    assign MDRTESTOUT = mdr;

    logic [31:0] hex_src;
    logic [6:0]  seg [8];

    assign hex_src = {pc, ir};

    generate
        for (genvar i = 0; i < 8; i++) begin : g_hex
            hexdriver u_hexdriver (
                .nibble (hex_src[4*i +: 4]),
                .seg    (seg[i])
            );
        end
    endgenerate

`ifdef SLC3_HEX_DISPLAY_EN
    assign HEX0 = seg[0];
    assign HEX1 = seg[1];
    assign HEX2 = seg[2];
    assign HEX3 = seg[3];
    assign HEX4 = seg[4];
    assign HEX5 = seg[5];
    assign HEX6 = seg[6];
    assign HEX7 = seg[7];
`else
    // Blank display; the OR keeps the decoder outputs referenced
    assign HEX0 = seg[0] | 7'h7F;
    assign HEX1 = seg[1] | 7'h7F;
    assign HEX2 = seg[2] | 7'h7F;
    assign HEX3 = seg[3] | 7'h7F;
    assign HEX4 = seg[4] | 7'h7F;
    assign HEX5 = seg[5] | 7'h7F;
    assign HEX6 = seg[6] | 7'h7F;
    assign HEX7 = seg[7] | 7'h7F;
`endif

endmodule
`default_nettype wire

// File: tb/tb_slc3_testtop.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_slc3_testtop: directed self-checking bench for slc3_testtop    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_slc3_testtop;
    import slc3_pkg::*;

    logic        Clk;
    logic        Run;
    logic        Continue;
    logic [9:0]  SW;
    logic [9:0]  LED;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
    logic [19:0] ADDR;
    logic [15:0] MARTESTOUT, PCTESTOUT, MDRTESTOUT;

    int n_assert = 0;
    int n_fail   = 0;

    slc3_testtop dut (
        .Clk        (Clk),
        .Run        (Run),
        .Continue   (Continue),
        .SW         (SW),
        .LED        (LED),
        .HEX0       (HEX0),
        .HEX1       (HEX1),
        .HEX2       (HEX2),
        .HEX3       (HEX3),
        .HEX4       (HEX4),
        .HEX5       (HEX5),
        .HEX6       (HEX6),
        .HEX7       (HEX7),
        .ADDR       (ADDR),
        .MARTESTOUT (MARTESTOUT),
        .PCTESTOUT  (PCTESTOUT),
        .MDRTESTOUT (MDRTESTOUT)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input state_t s, input string tag);
        int n = 0;
        while (dut.state !== s && n < 200) begin
            tick();
            n++;
        end
        check(tag, 64'(dut.state), 64'(s));
    endtask

    logic [55:0] hex_exp;

    initial begin
        Run = 1'b1;
        Continue = 1'b1;
        SW = 10'h155;
        tick();

        // Reset
        Run = 1'b0; Continue = 1'b0;
        tick();
        check("rst_pc",    PCTESTOUT, 16'h0000);
        check("rst_mar",   MARTESTOUT, 16'h0000);
        check("rst_mdr",   MDRTESTOUT, 16'h0000);
        check("rst_led",   LED, 10'h000);
        check("rst_addr",  ADDR, 20'h00000);
        check("rst_state", 64'(dut.state), 64'(S_HALTED));
        check("rst_cc",    dut.cc, 3'b010);

        // Idle with both buttons up holds HALTED
        Run = 1'b1; Continue = 1'b1;
        tick(); tick(); tick();
        check("idle_state", 64'(dut.state), 64'(S_HALTED));
        check("idle_pc",    PCTESTOUT, 16'h0000);

        // Press Run: HALTED->S18, then the S18 work, then S33 memory read
        Run = 1'b0;
        tick();
        check("run_s18", 64'(dut.state), 64'(S_18));
        tick();
        Run = 1'b1;
        check("fetch_mar",  MARTESTOUT, 16'h0000);
        check("fetch_pc",   PCTESTOUT, 16'h0001);
        check("fetch_addr", ADDR, 20'h00000);
        tick();
        check("fetch_mdr",  MDRTESTOUT, 16'h5020);

        // Run to the PAUSE at 0x02
        wait_state(S_PAUSE1, "reach_pause1");
        tick();
        check("pause_led", LED, 10'h0AA);
        check("pause_pc",  PCTESTOUT, 16'h0003);
        check("pause_ir",  dut.ir, 16'hD0AA);
        check("add_r0",    dut.regs[0], 16'h0003);
        check("add_cc",    dut.cc, 3'b001);

`ifdef SLC3_HEX_DISPLAY_EN
        hex_exp = {7'b1000000, 7'b1000000, 7'b1000000, 7'b0110000,
                   7'b0100001, 7'b1000000, 7'b0001000, 7'b0001000};
`else
        hex_exp = {8{7'h7F}};
`endif
        check("hex_digits", {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, hex_exp);

        // Stays paused while Continue is up
        tick(); tick(); tick(); tick(); tick();
        check("pause_hold_state", 64'(dut.state), 64'(S_PAUSE1));
        check("pause_hold_pc",    PCTESTOUT, 16'h0003);

        // Continue pulse: press then release
        Continue = 1'b0;
        tick();
        check("pause2", 64'(dut.state), 64'(S_PAUSE2));
        Continue = 1'b1;
        tick();
        check("resume_s18", 64'(dut.state), 64'(S_18));

        wait_state(S_LDR1, "reach_ldr1");
        check("str_mem10", dut.mem[16], 16'h0003);
        wait_state(S_BR, "reach_br");
        check("ldr_r2", dut.regs[2], 16'h0003);
        check("ldr_cc", dut.cc, 3'b001);
        tick();
        check("br_pc", PCTESTOUT, 16'h0002);

        wait_state(S_PAUSE1, "repause");
        tick();
        check("repause_led", LED, 10'h0AA);
        check("repause_pc",  PCTESTOUT, 16'h0003);

        // Another pulse, then reset in the middle of LDR
        Continue = 1'b0;
        tick();
        Continue = 1'b1;
        tick();
        wait_state(S_LDR2, "reach_ldr2");
        Run = 1'b0; Continue = 1'b0;
        tick();
        check("midrst_state", 64'(dut.state), 64'(S_HALTED));
        check("midrst_pc",    PCTESTOUT, 16'h0000);
        check("midrst_r2",    dut.regs[2], 16'h0000);
        check("midrst_led",   LED, 10'h000);
        check("midrst_cc",    dut.cc, 3'b010);
        check("midrst_mem10", dut.mem[16], 16'h0003);
        Run = 1'b1; Continue = 1'b1;
        tick(); tick();
        check("post_rst_state", 64'(dut.state), 64'(S_HALTED));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
